adder_control_system_pipe: RTL and testbench
============================================

Name: adder_control_system_pipe

Overview:
- Parametrised successor to the fixed-latency 64-bit add/sub controller.
- Pipelined two's-complement add/sub with programmable width and latency.
- Adds per-operation mode, optional saturation and an overflow flag.
- Carries a tag through the pipeline, supports valid/ready backpressure, flush and an in-flight counter. Used by the OPT datapath where result consumers can stall.

Parameters:
WIDTH, 64, operand/result width in bits (>=4)
LATENCY, 7, cycles from accepted operation to result valid (>=1)
TAG_W, 4, width of the user tag carried alongside each operation
SAT, 0, 1 = saturate on signed overflow, 0 = wrap

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
sta  input  1  operation valid
add_sub  input  1  1 = x+y, 0 = x-y (sampled with sta)
x  input  WIDTH  operand A, signed
y  input  WIDTH  operand B, signed
tag_in  input  TAG_W  user tag, sampled with sta
sta_rdy  output  1  block can accept an operation this cycle
flush  input  1  synchronous discard of all in-flight operations
xy  output  WIDTH  result
ovf  output  1  signed overflow occurred for this result (flagged even when saturated)
tag_out  output  TAG_W  tag of the current result
done_sig  output  1  result valid
res_rdy  input  1  consumer accepts result this cycle
inflight  output  clog2(LATENCY+1)+1  operations accepted and not yet consumed

Behaviour:
- Reset (rst=0, async): all stage valids=0; xy=0, ovf=0, tag_out=0, done_sig=0, inflight=0. sta_rdy=1 once reset is released.
- Accept: operation accepted when sta && sta_rdy on a rising edge.
- Stall: stall = done_sig && !res_rdy. sta_rdy = !stall (combinational).
  - On stall, every stage holds, including empty ones.
  - No bubble compression. The pipeline is a lock-step shift with a global enable.
- Arithmetic in stage 1, on WIDTH+1-bit sign-extended operands.
  - sum = x + (add_sub ? y : ~y + 1).
  - Overflow = sign bits of the two operands (y inverted for subtract) equal, and result sign differs.
  - Subtracting y = most-negative value is handled by the WIDTH+1 computation; overflow is derived from bit WIDTH vs bit WIDTH-1.
  - SAT=1 on overflow: positive overflow -> 0 followed by all ones; negative -> 1 followed by all zeros. SAT=0: low WIDTH bits.
  - Stages 2..LATENCY delay {valid, result, ovf, tag}.
- Latency: with no stall, an op accepted at edge N gives done_sig=1 and valid xy/ovf/tag_out after edge N+LATENCY-1, i.e. in cycle N+LATENCY. Throughput is 1 op/cycle.
- Output hold: while done_sig=1 && res_rdy=0, xy/ovf/tag_out are stable.
- Output when idle: when done_sig=0, xy/ovf/tag_out hold their last values. Consumers must ignore them.
- Inflight counter:
  - +1 on accept; -1 on done_sig && res_rdy; unchanged when both occur.
  - Never exceeds LATENCY. It is limited by the stall rule.
- Flush: clears all stage valids and inflight next edge, and overrides the same-cycle accept. The op is dropped; sta_rdy still reads 1 that cycle.
- Order: results leave in acceptance order. There is no loss or duplication under any res_rdy pattern.
- Reset mid-operation: all in-flight ops lost; state as reset values.

Test Plan:
- WIDTH=64, LATENCY=7: single add x=5, y=3, tag=2, res_rdy=1 -> done_sig=1 exactly 7 cycles after accept, xy=8, ovf=0, tag_out=2, inflight returns to 0.
- Subtract: x=3, y=5 -> xy=0xFFFFFFFFFFFFFFFE (-2), ovf=0. Then x=0, y=0x8000000000000000 subtract -> SAT=0: xy=0x8000000000000000, ovf=1; SAT=1: xy=0x7FFFFFFFFFFFFFFF, ovf=1.
- Add overflow x=0x7FFFFFFFFFFFFFFF, y=1 -> SAT=0: xy=0x8000000000000000, ovf=1; SAT=1: xy=0x7FFFFFFFFFFFFFFF, ovf=1.
- Back-to-back 10 ops, tags 0..9, res_rdy low for 3 cycles mid-stream -> sta_rdy=0 during stall, outputs held, all 10 results delivered in tag order with correct sums, inflight never >7.
- Flush asserted with 4 ops in flight and sta=1 same cycle -> no done_sig follows, inflight=0 next cycle.
- rst pulsed low asynchronously (between edges) with 5 ops in flight -> outputs 0 immediately; after release, a new op x=1, y=1 gives xy=2 after LATENCY cycles.

Source files
------------

// File: rtl/adder_control_system_pipe_if.sv
// Operation/result bus for the pipelined add/sub controller.
// master = producer/consumer side, slave = the pipeline itself.
interface adder_control_system_pipe_if #(
  parameter int WIDTH   = 64,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 7
);
  localparam int CNT_W = $clog2(LATENCY + 1) + 1;

  logic              sta;
  logic              add_sub;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic [TAG_W-1:0]  tag_in;
  logic              sta_rdy;
  logic              flush;
  logic [WIDTH-1:0]  xy;
  logic              ovf;
  logic [TAG_W-1:0]  tag_out;
  logic              done_sig;
  logic              res_rdy;
  logic [CNT_W-1:0]  inflight;

  modport master (
    output sta, add_sub, x, y, tag_in, flush, res_rdy,
    input  sta_rdy, xy, ovf, tag_out, done_sig, inflight
  );

  modport slave (
    input  sta, add_sub, x, y, tag_in, flush, res_rdy,
    output sta_rdy, xy, ovf, tag_out, done_sig, inflight
  );
endinterface

// File: rtl/adder_control_system_pipe.sv
// Pipelined signed add/sub with optional saturation, tag pass-through,
// valid/ready backpressure, flush and an in-flight operation counter.
// The pipe is a lock-step shift register with one global enable; a stalled
// output freezes every stage, empty ones included.
module adder_control_system_pipe #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 7,
  parameter int TAG_W   = 4,
  parameter int SAT     = 0
) (
  input logic                   clk,
  input logic                   rst,
  adder_control_system_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(LATENCY + 1) + 1;
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  logic [LATENCY:1]              vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][WIDTH-1:0]   res_pipe_q, res_pipe_d;
  logic [LATENCY:1]              ovf_pipe_q, ovf_pipe_d;
  logic [LATENCY:1][TAG_W-1:0]   tag_pipe_q, tag_pipe_d;
  logic [CNT_W-1:0]              inflight_q, inflight_d;

  logic             stall, shift, acc, cons;
  logic [WIDTH:0]   xe, ye, sum;
  logic             s1_ovf;
  logic [WIDTH-1:0] s1_res;

  // Stage-1 arithmetic on WIDTH+1 bits so that negating the most-negative
  // y cannot wrap; overflow is the disagreement of the two top sum bits.
  always_comb begin
    xe     = {bus.x[WIDTH-1], bus.x};
    ye     = bus.add_sub ? {bus.y[WIDTH-1], bus.y}
                         : ~{bus.y[WIDTH-1], bus.y} + ONE;
    sum    = xe + ye;
    s1_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    s1_res = sum[WIDTH-1:0];
    if (SAT != 0 && s1_ovf)
      s1_res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Handshake: stall only when a finished result is refused; flush wins
  // over a same-cycle accept.
  always_comb begin
    stall = vld_pipe_q[LATENCY] & ~bus.res_rdy;
    shift = ~stall & ~bus.flush;
    acc   = bus.sta & ~stall & ~bus.flush;
    cons  = vld_pipe_q[LATENCY] & bus.res_rdy;
  end

  // Next state of the pipe; payload only moves behind a valid so idle
  // stages (and the visible outputs) keep their last contents.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    res_pipe_d = res_pipe_q;
    ovf_pipe_d = ovf_pipe_q;
    tag_pipe_d = tag_pipe_q;
    if (bus.flush) begin
      vld_pipe_d = '0;
    end else if (shift) begin
      vld_pipe_d[1] = acc;
      if (acc) begin
        res_pipe_d[1] = s1_res;
        ovf_pipe_d[1] = s1_ovf;
        tag_pipe_d[1] = bus.tag_in;
      end
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        if (vld_pipe_q[k-1]) begin
          res_pipe_d[k] = res_pipe_q[k-1];
          ovf_pipe_d[k] = ovf_pipe_q[k-1];
          tag_pipe_d[k] = tag_pipe_q[k-1];
        end
      end
    end
  end

  // Accepted-but-not-consumed count; accept and consume in one cycle cancel.
  always_comb begin
    if (bus.flush) inflight_d = '0;
    else           inflight_d = inflight_q + CNT_W'(acc) - CNT_W'(cons);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      res_pipe_q <= '0;
      ovf_pipe_q <= '0;
      tag_pipe_q <= '0;
      inflight_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      res_pipe_q <= res_pipe_d;
      ovf_pipe_q <= ovf_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.sta_rdy  = ~stall;
  assign bus.done_sig = vld_pipe_q[LATENCY];
  assign bus.xy       = res_pipe_q[LATENCY];
  assign bus.ovf      = ovf_pipe_q[LATENCY];
  assign bus.tag_out  = tag_pipe_q[LATENCY];
  assign bus.inflight = inflight_q;
endmodule

// File: tb/tb_adder_control_system_pipe.sv
// Scoreboard bench for adder_control_system_pipe: a reference model pushes
// expected results on accept, a negedge monitor pops and compares them.
module tb_adder_control_system_pipe;
  localparam int W   = 64;
  localparam int L   = 7;
  localparam int TW  = 4;
  localparam int SAT = 0;

  typedef struct {
    logic [W-1:0]  xy;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk, rst;
  int   n_chk, n_err;
  exp_t sb[$];

  adder_control_system_pipe_if #(.WIDTH(W), .TAG_W(TW), .LATENCY(L)) bus();

  adder_control_system_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(TW), .SAT(SAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic on W+2 bits, range-checked.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic add, input logic [TW-1:0] t);
    logic signed [W+1:0] ea, eb, r, mx, mn;
    exp_t e;
    ea = {{2{a[W-1]}}, a};
    eb = {{2{b[W-1]}}, b};
    r  = add ? ea + eb : ea - eb;
    mx = {3'b000, {(W-1){1'b1}}};
    mn = {3'b111, {(W-1){1'b0}}};
    e.ovf = (r > mx) || (r < mn);
    e.xy  = r[W-1:0];
    if (e.ovf && SAT != 0) e.xy = (r > mx) ? mx[W-1:0] : mn[W-1:0];
    e.tag = t;
    return e;
  endfunction

  // Monitor: inflight vs scoreboard depth, output hold under stall,
  // result compare on consume, expectation push on accept.
  initial begin
    logic         prev_stall;
    logic [W-1:0] h_xy;
    logic         h_ovf;
    logic [TW-1:0] h_tag;
    exp_t e;
    prev_stall = 1'b0;
    h_xy = '0; h_ovf = 1'b0; h_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("inflight", bus.inflight, sb.size());
        chk("infl_max", bus.inflight <= L, 1);
        if (prev_stall) begin
          chk("hold_xy", bus.xy, h_xy);
          chk("hold_ovf", bus.ovf, h_ovf);
          chk("hold_tag", bus.tag_out, h_tag);
        end
        prev_stall = bus.done_sig && !bus.res_rdy;
        h_xy = bus.xy; h_ovf = bus.ovf; h_tag = bus.tag_out;
        if (bus.flush) begin
          sb.delete();
        end else begin
          if (bus.done_sig && bus.res_rdy) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
              e = sb.pop_front();
              chk("xy", bus.xy, e.xy);
              chk("ovf", bus.ovf, e.ovf);
              chk("tag", bus.tag_out, e.tag);
            end
          end
          if (bus.sta && bus.sta_rdy) sb.push_back(model(bus.x, bus.y, bus.add_sub, bus.tag_in));
        end
      end
    end
  end

  // Present one op and hold it until the edge that accepts it; returns at
  // posedge+1 with sta still high.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic add, input logic [TW-1:0] t);
    int n;
    bus.sta = 1'b1; bus.x = a; bus.y = b; bus.add_sub = add; bus.tag_in = t;
    n = 0;
    @(negedge clk);
    while (!bus.sta_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_wait", n < 100, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.done_sig) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [W-1:0] mn, mx;
    n_chk = 0; n_err = 0;
    mn = {1'b1, {(W-1){1'b0}}};
    mx = {1'b0, {(W-1){1'b1}}};
    rst = 1'b0;
    bus.sta = 1'b0; bus.add_sub = 1'b1; bus.x = '0; bus.y = '0; bus.tag_in = '0;
    bus.flush = 1'b0; bus.res_rdy = 1'b1;

    // Reset state
    #2;
    chk("rst_xy", bus.xy, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_tag", bus.tag_out, 0);
    chk("rst_done", bus.done_sig, 0);
    chk("rst_infl", bus.inflight, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_rdy", bus.sta_rdy, 1);
    @(posedge clk); #1;

    // Single add and its latency
    send(5, 3, 1'b1, 2);
    bus.sta = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.done_sig && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("latency", n, L - 1);
    chk("add_xy", bus.xy, 8);
    @(posedge clk); #1;
    chk("infl_zero", bus.inflight, 0);

    // Subtract and overflow corners
    send(3, 5, 1'b0, 3);
    send(0, mn, 1'b0, 4);
    send(mx, 1, 1'b1, 5);
    send(mn, 1, 1'b0, 6);
    send(mn, mn, 1'b1, 7);
    bus.sta = 1'b0;
    drain();

    // Ten back-to-back ops with a three-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 10; i++) send(W'(i * 3 + 1), W'(i * 5), 1'(i % 2), TW'(i));
        bus.sta = 1'b0;
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!bus.done_sig && m < 50) begin
          m++;
          @(negedge clk);
        end
        chk("stall_wait", m < 50, 1);
        @(posedge clk); #1 bus.res_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_rdy", bus.sta_rdy, 0);
          chk("stall_done", bus.done_sig, 1);
        end
        @(posedge clk); #1 bus.res_rdy = 1'b1;
      end
    join
    drain();

    // Flush with four in flight and an accept in the same cycle
    for (int i = 0; i < 4; i++) send(W'(100 + i), W'(i), 1'b1, TW'(i));
    bus.x = 77; bus.tag_in = 15; bus.flush = 1'b1;
    #1 chk("flush_rdy", bus.sta_rdy, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.sta = 1'b0;
    chk("flush_infl", bus.inflight, 0);
    chk("flush_done", bus.done_sig, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_sig) n++;
    end
    chk("flush_quiet", n, 0);
    @(posedge clk); #1;

    // Asynchronous reset with five in flight
    for (int i = 0; i < 5; i++) send(W'(200 + i), W'(1), 1'b1, TW'(i));
    bus.sta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_done", bus.done_sig, 1);
    bus.res_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_xy", bus.xy, 0);
    chk("arst_tag", bus.tag_out, 0);
    chk("arst_done", bus.done_sig, 0);
    chk("arst_infl", bus.inflight, 0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b1; bus.res_rdy = 1'b1;
    @(posedge clk); #1;
    send(1, 1, 1'b1, 9);
    bus.sta = 1'b0;
    drain();

    // Random traffic with random consumer readiness
    fork
      begin
        for (int i = 0; i < 24; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), TW'(i));
        bus.sta = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge clk); #1 bus.res_rdy = 1'($urandom_range(0, 1));
        end
        bus.res_rdy = 1'b1;
      end
    join
    bus.res_rdy = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
